std_seq_div: RTL
================

// Module: std_seq_div
// PURPOSE
//  Iterative unsigned restoring divider: the multi-cycle neighbour of the
//  combinational arithmetic primitives. Produces quotient and remainder that
//  feed std_reg stages downstream.
//  Accepts operands on the valid/read_in handshake. Computes one quotient bit
//  per cycle. Signals completion with a single-cycle ready/out_read_out pulse.
// PARAMETERS
//  width  32  operand/result bit width; legal range 2..64
// PORTS
//  clk            in   1      clock; all state updates on posedge
//  reset          in   1      synchronous, active-high reset
//  left           in   width  dividend
//  left_read_in   in   1      dividend is valid
//  right          in   width  divisor
//  right_read_in  in   1      divisor is valid
//  valid          in   1      start request
//  ready          out  1      one-cycle completion pulse
//  out            out  width  quotient
//  out_remainder  out  width  remainder
//  out_read_out   out  1      equals ready; out/out_remainder are valid
//  div_by_zero    out  1      present only under STD_SEQ_DIV_ZERO_CHECK_EN
// BEHAVIOUR
//  - Reset (sync, active-high; wins over everything, including mid-operation):
//    state=IDLE; ready=0; out_read_out=0; out=0; out_remainder=0;
//    div_by_zero=0. No partial result is ever published.
//  - States: IDLE, BUSY, DONE.
//  - IDLE: start = valid && left_read_in && right_read_in. On start:
//    latch left and right, clear the partial remainder, set cnt=width, go BUSY.
//    If start is not met, stay in IDLE.
//  - BUSY, one step per cycle:
//    r' = {rem[width-1:0], dvd[width-1]}  (width+1 bits);
//    dvd <<= 1;
//    if r' >= {1'b0,divisor}: rem = r' - divisor, quotient bit = 1;
//    else: rem = r', quotient bit = 0.
//    Quotient bits shift into dvd LSB. cnt decrements; when cnt==1, go DONE.
//  - DONE: register out = quotient and out_remainder = rem[width-1:0].
//    Assert ready=out_read_out=1 for exactly this cycle, then go IDLE.
//  - Latency: start sampled in cycle 0 -> BUSY in cycles 1..width ->
//    ready high in cycle width+1.
//  - Back-to-back: with valid held high, the next start is sampled in the IDLE
//    cycle after DONE. Period is width+2 cycles.
//  - Inputs are ignored while BUSY or DONE; operands are latched and may change
//    freely after start.
//  - out/out_remainder hold the last result until the next DONE.
//  - Divisor 0 (default build): the algorithm runs its full course.
//    Result: out = all ones, out_remainder = left.
//  - Counter width is $clog2(width+1). No wrap is possible: cnt is reloaded
//    only in IDLE.
// CONFIGURATION
//  STD_SEQ_DIV_ZERO_CHECK_EN
//  - Defined: port div_by_zero exists. Start with right==0 skips BUSY and goes
//    directly to DONE in cycle 1, with out = all ones, out_remainder = left,
//    div_by_zero=1. div_by_zero is held until the next DONE, which rewrites it.
//  - Undefined: the port is absent; divisor 0 takes full latency as above.
// STRUCTURE
//  - Package std_seq_div_pkg: typedef enum logic [1:0] {IDLE, BUSY, DONE}
//    seq_div_state_t.
//  - Sub-module std_div_step: combinational single iteration.
//    Inputs: rem, dvd_msb, divisor. Outputs: next rem, quotient bit.
//    Parameterised by width.
//  - Top: state register, counter, operand/remainder registers, result
//    registers.
// TESTING (width=8 unless noted)
//  1. left=100, right=7, valid pulsed in cycle 0 -> ready=out_read_out=1 only
//     in cycle 9; out=14, out_remainder=2.
//  2. left=255, right=1, then left=3, right=200 -> results 255/0, then 0/3.
//  3. left=5, right=0 -> out=255, rem=5.
//     Default build: ready in cycle 9.
//     With _EN: ready in cycle 1 and div_by_zero=1.
//  4. valid=1, right_read_in=0 for 5 cycles -> stays IDLE, ready never high.
//     Raise right_read_in -> start is taken that cycle.
//  5. reset asserted in cycle 4 of BUSY -> next cycle IDLE with all outputs 0.
//     Re-issue 100/7 -> correct result 14/2.
//  6. valid held high, 4 operand pairs, randomised width=32 vs reference model
//     -> results match; ready pulses exactly every 34 cycles.

Source files
------------

// File: rtl/std_seq_div_pkg.sv
// Shared types for the iterative restoring divider std_seq_div.
package std_seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_div_state_t;

endpackage

// File: rtl/std_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when the shifted partial remainder is large enough.
module std_div_step #(
    parameter int width = 32
) (
    input  logic [width-1:0] rem,
    input  logic             dvd_msb,
    input  logic [width-1:0] divisor,
    output logic [width-1:0] rem_next,
    output logic             q_bit
);

    logic [width:0] shifted;

    assign shifted = {rem, dvd_msb};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // Difference is below the divisor, so the low width bits are exact.
    assign rem_next = q_bit ? (shifted[width-1:0] - divisor) : shifted[width-1:0];

endmodule

// File: rtl/std_seq_div.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Optional macro STD_SEQ_DIV_ZERO_CHECK_EN adds the div_by_zero port and a fast path.
module std_seq_div
    import std_seq_div_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] left,
    input  logic             left_read_in,
    input  logic [width-1:0] right,
    input  logic             right_read_in,
    input  logic             valid,
    output logic             ready,
    output logic [width-1:0] out,
    output logic [width-1:0] out_remainder,
    output logic             out_read_out
`ifdef STD_SEQ_DIV_ZERO_CHECK_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int CNT_W = $clog2(width + 1);

    seq_div_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [width-1:0] dvd_q, dvd_d;
    logic [width-1:0] divisor_q, divisor_d;
    logic [width-1:0] rem_q, rem_d;
    logic [width-1:0] out_q, out_d;
    logic [width-1:0] out_rem_q, out_rem_d;

    logic             start;
    logic             start_zero;
    logic             last_step;
    logic [width-1:0] step_rem;
    logic             step_q_bit;
    logic [width-1:0] quotient_next;

    assign start     = valid && left_read_in && right_read_in;
    assign last_step = (cnt_q == CNT_W'(1));

`ifdef STD_SEQ_DIV_ZERO_CHECK_EN
    logic dbz_q, dbz_d;
    assign start_zero  = (right == '0);
    assign div_by_zero = dbz_q;
`else
    assign start_zero  = 1'b0;
`endif

    std_div_step #(
        .width(width)
    ) u_step (
        .rem     (rem_q),
        .dvd_msb (dvd_q[width-1]),
        .divisor (divisor_q),
        .rem_next(step_rem),
        .q_bit   (step_q_bit)
    );

    // Quotient bits accumulate in the dividend register as it shifts out.
    assign quotient_next = {dvd_q[width-2:0], step_q_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = start_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready         = (state_q == DONE);
        out_read_out  = (state_q == DONE);
        out           = out_q;
        out_remainder = out_rem_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        out_d     = out_q;
        out_rem_d = out_rem_q;
`ifdef STD_SEQ_DIV_ZERO_CHECK_EN
        dbz_d     = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = left;
                    divisor_d = right;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(width);
                    if (start_zero) begin
                        out_d     = '1;
                        out_rem_d = left;
`ifdef STD_SEQ_DIV_ZERO_CHECK_EN
                        dbz_d     = 1'b1;
`endif
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                dvd_d = quotient_next;
                cnt_d = cnt_q - CNT_W'(1);
                // Results are loaded on entry to DONE so they are valid with ready.
                if (last_step) begin
                    out_d     = quotient_next;
                    out_rem_d = step_rem;
`ifdef STD_SEQ_DIV_ZERO_CHECK_EN
                    dbz_d     = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            dvd_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            out_q     <= '0;
            out_rem_q <= '0;
`ifdef STD_SEQ_DIV_ZERO_CHECK_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            out_q     <= out_d;
            out_rem_q <= out_rem_d;
`ifdef STD_SEQ_DIV_ZERO_CHECK_EN
            dbz_q     <= dbz_d;
`endif
        end
    end

endmodule
